// File: rtl/burst_line_reader_if.sv
// rtl/burst_line_reader_if.sv - client-side and DDR-side ports of the burst line reader
interface burst_line_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  io_flush;
  logic                  io_in_rd;
  logic [ADDR_WIDTH-1:0] io_in_addr;
  logic                  io_in_wait_n;
  logic                  io_in_valid;
  logic [DATA_WIDTH-1:0] io_in_dout;
  logic                  io_out_rd;
  logic [ADDR_WIDTH-1:0] io_out_addr;
  logic [7:0]            io_out_burstLength;
  logic                  io_out_waitReq;
  logic                  io_out_valid;
  logic [DATA_WIDTH-1:0] io_out_dout;

  // The cache itself: takes client reads, issues DDR bursts
  modport slave (
    input  io_flush, io_in_rd, io_in_addr, io_out_waitReq, io_out_valid, io_out_dout,
    output io_in_wait_n, io_in_valid, io_in_dout, io_out_rd, io_out_addr, io_out_burstLength
  );

  // The surroundings: crossing FIFO on one side, DDR on the other
  modport master (
    output io_flush, io_in_rd, io_in_addr, io_out_waitReq, io_out_valid, io_out_dout,
    input  io_in_wait_n, io_in_valid, io_in_dout, io_out_rd, io_out_addr, io_out_burstLength
  );
endinterface

// File: rtl/burst_line_reader.sv
// rtl/burst_line_reader.sv - single-line blocking read cache filled by DDR bursts
module burst_line_reader #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  burst_line_reader_if.slave  bus
);
  localparam int OFS = $clog2(DATA_WIDTH / 8);
  localparam int LB  = $clog2(BURST_LENGTH);
  localparam int TW  = ADDR_WIDTH - OFS - LB;
  localparam logic [LB-1:0] LAST_IDX = LB'(BURST_LENGTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_line [BURST_LENGTH];
  logic [TW-1:0]         r_tag;
  logic                  r_line_valid;
  logic [LB-1:0]         r_cnt;
  logic                  r_flush_pend;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_dout;

  logic [TW-1:0]         w_req_tag;
  logic [LB-1:0]         w_req_idx;
  logic [LB-1:0]         w_lat_idx;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fill_wr;
  logic                  w_last;
  logic                  w_unused;

  assign w_req_tag = bus.io_in_addr[ADDR_WIDTH-1:OFS+LB];
  assign w_req_idx = bus.io_in_addr[OFS+LB-1:OFS];
  assign w_lat_idx = r_addr[OFS+LB-1:OFS];
  assign w_accept  = bus.io_in_rd & (r_state == S_IDLE);
  // A flush arriving with the request must not be answered from the stale line
  assign w_hit     = w_accept & r_line_valid & (w_req_tag == r_tag) & ~bus.io_flush;
  assign w_miss    = w_accept & ~w_hit;
  assign w_fill_wr = (r_state == S_FILL) & bus.io_out_valid;
  assign w_last    = w_fill_wr & (r_cnt == LAST_IDX);
  assign w_unused  = ^{bus.io_in_addr[OFS-1:0], r_addr[OFS-1:0]};

  assign bus.io_in_wait_n       = (r_state == S_IDLE);
  assign bus.io_in_valid        = r_valid;
  assign bus.io_in_dout         = r_dout;
  assign bus.io_out_rd          = (r_state == S_REQ);
  assign bus.io_out_addr        = {r_addr[ADDR_WIDTH-1:OFS+LB], {(OFS+LB){1'b0}}};
  assign bus.io_out_burstLength = 8'(BURST_LENGTH);

  // Next-state selection for the miss sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_miss) w_next = S_REQ;
      S_REQ:   if (!bus.io_out_waitReq) w_next = S_FILL;
      S_FILL:  if (w_last) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Line storage: only burst beats inside FILL are written, stray strobes are dropped
  always_ff @(posedge clock) begin
    if (w_fill_wr) r_line[r_cnt] <= bus.io_out_dout;
  end

  // State register, response path, line bookkeeping and flush handling
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_line_valid <= 1'b0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_addr       <= '0;
      r_valid      <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      if (w_accept) r_addr <= bus.io_in_addr;
      if (w_hit) begin
        r_valid <= 1'b1;
        r_dout  <= r_line[w_req_idx];
      end
      if (w_fill_wr) r_cnt <= r_cnt + LB'(1);
      if (w_last) begin
        r_line_valid <= 1'b1;
        r_tag        <= r_addr[ADDR_WIDTH-1:OFS+LB];
        r_valid      <= 1'b1;
        // The final beat is not in the array yet, so bypass it when it is the one asked for
        r_dout       <= (w_lat_idx == LAST_IDX) ? bus.io_out_dout : r_line[w_lat_idx];
      end
      case (r_state)
        S_IDLE: if (bus.io_flush) r_line_valid <= 1'b0;
        S_REQ, S_FILL: if (bus.io_flush) r_flush_pend <= 1'b1;
        S_RESP: if (bus.io_flush || r_flush_pend) begin
          r_line_valid <= 1'b0;
          r_flush_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
